// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared next-PC op encodings, trap cause codes and PC FSM states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] NPC_OP_PC4    = 2'b00;
  localparam logic [1:0] NPC_OP_JALR   = 2'b01;
  localparam logic [1:0] NPC_OP_BRANCH = 2'b10;
  localparam logic [1:0] NPC_OP_JAL    = 2'b11;

  localparam int unsigned CAUSE_IMISALIGN = 0;
  localparam int unsigned CAUSE_ILLEGAL   = 2;
  localparam int unsigned CAUSE_ECALL     = 11;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_HALT    = 2'd2
  } pc_state_e;

endpackage

`default_nettype wire

// File: rtl/npc_target.sv
// ============================================================================
// Module  : npc_target
// Brief   : Combinational next-PC target select with JALR LSB clear and
//           instruction-misalignment flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_target
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32
) (
  input  logic [1:0]      op,
  input  logic            if_branch,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ra,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] tgt,
  output logic            mis
);

  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_jalr;

  assign w_pc4    = pc + XLEN'(4);
  assign w_pc_imm = pc + imm;
  assign w_jalr   = (ra + imm) & ~XLEN'(1);

  always_comb begin
    tgt = w_pc4;
    case (op)
      NPC_OP_PC4:    tgt = w_pc4;
      NPC_OP_JALR:   tgt = w_jalr;
      NPC_OP_BRANCH: tgt = if_branch ? w_pc_imm : w_pc4;
      NPC_OP_JAL:    tgt = w_pc_imm;
      default:       tgt = w_pc4;
    endcase
  end

  // With compressed instructions (IALIGN=16) every even target is legal.
  generate
    if (IALIGN == 32) begin : g_align32
      assign mis = tgt[1];
    end else begin : g_align16
      assign mis = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module  : pc_unit
// Brief   : Architectural PC register, next-PC generation and trap entry/return
//           with a RUN/HANDLER/HALT state machine (sticky double fault).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 32,
  parameter int              CAUSE_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [1:0]         op,
  input  logic               if_branch,
  input  logic [XLEN-1:0]    ra,
  input  logic [XLEN-1:0]    imm,
  input  logic               trap_req,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic               mret,
  input  logic [XLEN-1:0]    mtvec,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc4,
  output logic [XLEN-1:0]    npc,
  output logic [XLEN-1:0]    mepc,
  output logic [CAUSE_W-1:0] mcause,
  output logic [XLEN-1:0]    mtval,
  output logic               trap_taken,
  output logic               in_handler,
  output logic               halted
);

  pc_state_e          r_state;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_mepc;
  logic [CAUSE_W-1:0] r_mcause;
  logic [XLEN-1:0]    r_mtval;
  logic               r_in_handler;
  logic               r_halted;

  logic [XLEN-1:0]    w_tgt;
  logic               w_mis;
  logic [XLEN-1:0]    w_tvec;
  logic               w_active;
  logic               w_trap;
  logic               w_mret_ok;
  logic [XLEN-1:0]    w_npc;
  logic               w_unused_mtvec;

  npc_target #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_npc_target (
    .op        (op),
    .if_branch (if_branch),
    .pc        (r_pc),
    .ra        (ra),
    .imm       (imm),
    .tgt       (w_tgt),
    .mis       (w_mis)
  );

  assign w_tvec         = {mtvec[XLEN-1:2], 2'b00};
  assign w_unused_mtvec = ^mtvec[1:0];

  // Stall and HALT both freeze the unit; nothing below may fire then.
  assign w_active  = !stall && (r_state != ST_HALT);
  assign w_trap    = w_active && (trap_req || w_mis);
  assign w_mret_ok = w_active && !w_trap && mret && (r_state == ST_HANDLER);

  always_comb begin
    w_npc = r_pc;
    if (w_trap) begin
      w_npc = w_tvec;
    end else if (w_mret_ok) begin
      w_npc = r_mepc;
    end else if (w_active) begin
      w_npc = w_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_VEC;
      r_mepc       <= '0;
      r_mcause     <= '0;
      r_mtval      <= '0;
      r_in_handler <= 1'b0;
      r_halted     <= 1'b0;
    end else if (w_active) begin
      r_pc <= w_npc;
      if (w_trap) begin
        r_mepc   <= r_pc;
        r_mcause <= trap_req ? trap_cause : CAUSE_W'(CAUSE_IMISALIGN);
        r_mtval  <= trap_req ? '0 : w_tgt;
        // A fault while already handling one is unrecoverable.
        if (r_state == ST_RUN) begin
          r_state      <= ST_HANDLER;
          r_in_handler <= 1'b1;
        end else begin
          r_state      <= ST_HALT;
          r_in_handler <= 1'b0;
          r_halted     <= 1'b1;
        end
      end else if (w_mret_ok) begin
        r_state      <= ST_RUN;
        r_in_handler <= 1'b0;
      end
    end
  end

  assign pc         = r_pc;
  assign pc4        = r_pc + XLEN'(4);
  assign npc        = w_npc;
  assign mepc       = r_mepc;
  assign mcause     = r_mcause;
  assign mtval      = r_mtval;
  assign trap_taken = w_trap;
  assign in_handler = r_in_handler;
  assign halted     = r_halted;

endmodule

`default_nettype wire
